// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver.
// Frame: start bit, 8 data bits LSB first, optional parity bit, 1 stop bit.
// Each bit spans PRESCALE clk cycles. The bit value is a 3-sample majority
// taken around the bit centre. Optional build macro UART_RX_SYNC_EN adds a
// 2-flop input synchronizer, which delays every event by 2 cycles.
module uart_rx #(
    parameter int PRESCALE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX_IN,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    output logic [7:0] P_DATA,
    output logic       data_valid,
    output logic       par_err,
    output logic       stp_err,
    output logic       busy
);

    localparam int CW = $clog2(PRESCALE);
    localparam int M  = PRESCALE / 2;

    localparam logic [CW-1:0] TICK_S0   = CW'(M - 1);
    localparam logic [CW-1:0] TICK_S1   = CW'(M);
    localparam logic [CW-1:0] TICK_RES  = CW'(M + 1);
    localparam logic [CW-1:0] TICK_LAST = CW'(PRESCALE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            rx_s;
    logic [CW-1:0]   edge_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift_q;
    logic            s0_q;
    logic            s1_q;
    logic            par_en_q;
    logic            par_typ_q;
    logic            par_bad_q;
    logic            break_wait_q;

    logic            at_res;
    logic            at_last;
    logic            maj;
    logic            arm;
    logic            start_ok;
    logic            frame_done;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], RX_IN};
        end
    end

    assign rx_s = sync_q[1];
`else
    assign rx_s = RX_IN;
`endif

    assign at_res  = (edge_cnt == TICK_RES);
    assign at_last = (edge_cnt == TICK_LAST);
    // Third sample is the live line value at tick M+1.
    assign maj     = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next
        // unassigned, which would otherwise infer a latch.
        state_next = state;
        case (state)
            IDLE: begin
                if (!break_wait_q && !rx_s) state_next = START;
            end
            START: begin
                if (at_res && maj)   state_next = IDLE;
                else if (at_last)    state_next = DATA;
            end
            DATA: begin
                if (at_last && (bit_cnt == 3'd7)) begin
                    state_next = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (at_last) state_next = STOP;
            end
            STOP: begin
                if (at_res) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Decoded strobes and the busy output.
    always_comb begin
        busy       = (state != IDLE);
        arm        = (state == IDLE) && !break_wait_q && !rx_s;
        start_ok   = (state == START) && at_res && !maj;
        frame_done = (state == STOP) && at_res;
    end

    // Counters, bit samples, shift register, frame flags and output pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_cnt     <= '0;
            bit_cnt      <= '0;
            shift_q      <= '0;
            s0_q         <= 1'b1;
            s1_q         <= 1'b1;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_bad_q    <= 1'b0;
            break_wait_q <= 1'b0;
            P_DATA       <= '0;
            data_valid   <= 1'b0;
            par_err      <= 1'b0;
            stp_err      <= 1'b0;
        end else begin
            // The detecting IDLE cycle is tick 0, so START begins at tick 1.
            if (state == IDLE) begin
                edge_cnt <= arm ? CW'(1) : '0;
            end else if (at_last || (state_next != state)) begin
                edge_cnt <= '0;
            end else begin
                edge_cnt <= edge_cnt + 1'b1;
            end

            if (state != DATA) begin
                bit_cnt <= '0;
            end else if (at_last) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (state != IDLE) begin
                if (edge_cnt == TICK_S0) s0_q <= rx_s;
                if (edge_cnt == TICK_S1) s1_q <= rx_s;
            end

            // Frame configuration is frozen once the start bit is confirmed.
            if (start_ok) begin
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
                par_bad_q <= 1'b0;
            end

            // Shifting right with MSB entry restores LSB-first order.
            if ((state == DATA) && at_res) begin
                shift_q <= {maj, shift_q[7:1]};
            end

            // Expected parity bit: XOR of data, inverted for odd parity.
            if ((state == PARITY) && at_res) begin
                par_bad_q <= (maj != ((^shift_q) ^ par_typ_q));
            end

            // A zero stop bit may be a line break; wait for the line to
            // return high before re-arming.
            if (frame_done && !maj) begin
                break_wait_q <= 1'b1;
            end else if ((state == IDLE) && rx_s) begin
                break_wait_q <= 1'b0;
            end

            if (frame_done) begin
                P_DATA     <= shift_q;
                par_err    <= par_bad_q;
                stp_err    <= !maj;
                data_valid <= !par_bad_q && maj;
            end else begin
                par_err    <= 1'b0;
                stp_err    <= 1'b0;
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with a frame scoreboard.
// Each driven frame pushes its expected result and pulse cycle; a monitor
// pops and compares whenever the receiver pulses an output.
module tb_uart_rx;

    localparam int PRESCALE = 8;
`ifdef UART_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic       busy;

    uart_rx #(.PRESCALE(PRESCALE)) dut (
        .clk        (clk),
        .rst        (rst),
        .RX_IN      (rx_in),
        .PAR_EN     (par_en),
        .PAR_TYP    (par_typ),
        .P_DATA     (p_data),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic       dv;
        logic       pe;
        logic       se;
        int         at;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   pushed = 0;
    int   pulses = 0;
    int   busy_rise = -1;
    int   busy_fall = -1;
    int   busy_rises = 0;
    logic busy_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Correct parity bit: total count of ones (data + parity) even or odd.
    function automatic logic good_par(input logic [7:0] d, input logic odd);
        int ones;
        ones = $countones(d);
        return ((ones % 2) == 1) ? !odd : odd;
    endfunction

    // Drives one full frame starting now, including the whole stop bit.
    task automatic send(input logic [7:0] d, input logic pe, input logic pt,
                        input logic par_bit, input logic stop_bit, input logic flip_mid);
        exp_t e;
        int   ones;
        par_en  = pe;
        par_typ = pt;
        rx_in   = 1'b0;
        ones    = $countones(d) + int'(par_bit);
        e.data  = d;
        e.pe    = pe && ((ones % 2) != int'(pt));
        e.se    = !stop_bit;
        e.dv    = !e.pe && !e.se;
        e.at    = cyc + (9 + int'(pe)) * PRESCALE + PRESCALE / 2 + 2 + LAT;
        sb.push_back(e);
        pushed++;
        step(PRESCALE);
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            if (flip_mid && (i == 2)) begin
                par_en  = !pe;
                par_typ = !pt;
            end
            step(PRESCALE);
        end
        if (pe) begin
            rx_in = par_bit;
            step(PRESCALE);
        end
        rx_in = stop_bit;
        step(PRESCALE);
    endtask

    initial begin
        int         s;
        int         pr;
        int         pc;
        logic [7:0] d;

        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (!rst) begin
                    if (busy && !busy_prev) begin
                        busy_rise = cyc;
                        busy_rises++;
                    end
                    if (!busy && busy_prev) busy_fall = cyc;
                    if (data_valid || par_err || stp_err) begin
                        pulses++;
                        if (sb.size() == 0) begin
                            check("unexpected_pulse", 32'({data_valid, par_err, stp_err}), 32'd0);
                        end else begin
                            e = sb.pop_front();
                            check("pulse_cycle", 32'(cyc), 32'(e.at));
                            check("p_data", 32'(p_data), 32'(e.data));
                            check("data_valid", 32'(data_valid), 32'(e.dv));
                            check("par_err", 32'(par_err), 32'(e.pe));
                            check("stp_err", 32'(stp_err), 32'(e.se));
                        end
                    end
                end
                busy_prev = busy;
            end
        join_none

        // Reset state.
        rst = 1'b1;
        step(4);
        check("rst_p_data", 32'(p_data), 32'd0);
        check("rst_outputs", 32'({data_valid, par_err, stp_err}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step(4);

        // 0xA5, no parity: pulse at 78, busy over cycles 1..77.
        s = cyc;
        send(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("a5_busy_rise", 32'(busy_rise), 32'(s + 1 + LAT));
        check("a5_busy_fall", 32'(busy_fall), 32'(s + 78 + LAT));

        // Even parity 0x3C: correct parity bit, then wrong one.
        send(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        send(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

        // Two-cycle glitch: back to IDLE at tick M+1, no pulses.
        step(4);
        pc = pulses;
        s = cyc;
        rx_in = 1'b0;
        step(2);
        rx_in = 1'b1;
        step(20);
        check("glitch_busy_rise", 32'(busy_rise), 32'(s + 1 + LAT));
        check("glitch_busy_fall", 32'(busy_fall), 32'(s + 6 + LAT));
        check("glitch_no_pulse", 32'(pulses), 32'(pc));

        // Stop bit 0 and line held low: one stp_err, no re-arm while low.
        pr = busy_rises;
        send(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(40);
        check("break_busy", 32'(busy), 32'd0);
        check("break_no_rearm", 32'(busy_rises), 32'(pr + 1));
        rx_in = 1'b1;
        step(2);
        send(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Back-to-back odd parity; mid-frame PAR_EN/PAR_TYP change ignored.
        step(3);
        send(8'h00, 1'b1, 1'b1, good_par(8'h00, 1'b1), 1'b1, 1'b0);
        send(8'hFF, 1'b1, 1'b1, good_par(8'hFF, 1'b1), 1'b1, 1'b1);
        send(8'h96, 1'b1, 1'b1, good_par(8'h96, 1'b1), 1'b1, 1'b0);

        // Reset during data bit 4 discards the partial frame.
        step(4);
        d = 8'h5A;
        par_en = 1'b0;
        rx_in = 1'b0;
        step(PRESCALE);
        for (int i = 0; i < 4; i++) begin
            rx_in = d[i];
            step(PRESCALE);
        end
        rx_in = d[4];
        step(3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("midrst_p_data", 32'(p_data), 32'd0);
        check("midrst_outputs", 32'({data_valid, par_err, stp_err}), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        rx_in = 1'b1;
        step(16);
        send(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Bounded drain of any outstanding expectations.
        for (int i = 0; (i < 200) && (sb.size() != 0); i++) step(1);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        check("pulse_count", 32'(pulses), 32'(pushed));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Oversampling UART receiver; the downstream stage of the UART transmitter, consuming its serial line. Recovers start + 8 data bits (LSB first) + optional parity + 1 stop bit from `RX_IN`, running at `PRESCALE`× the transmitter's bit clock. Presents the received byte on `P_DATA` with a one-cycle `data_valid` pulse, and flags parity and stop-bit errors.

## Interface
- `PRESCALE`, 8: clk cycles per bit; even, 4..32.
- `clk` in 1: receiver clock, `PRESCALE`× TX bit rate.
- `rst` in 1: synchronous, active-high reset.
- `RX_IN` in 1: serial line; idle high.
- `PAR_EN` in 1: 1 = frame carries a parity bit.
- `PAR_TYP` in 1: 0 = even, 1 = odd.
- `P_DATA` out 8: last received byte. Reset 0.
- `data_valid` out 1: one-cycle pulse, error-free frame. Reset 0.
- `par_err` out 1: one-cycle pulse, parity mismatch. Reset 0.
- `stp_err` out 1: one-cycle pulse, stop bit sampled 0. Reset 0.
- `busy` out 1: high in every state except IDLE. Reset 0.

## Operation
- Registers:
  - `edge_cnt` counts 0..PRESCALE-1 within each bit.
  - `bit_cnt` counts 0..7 data bits.
  - 8-bit shift register fills MSB-in, shifting right, so LSB-first order is restored.
- Let M = PRESCALE/2. `rx_s` is the sampled line (see Configuration).
- Samples are taken at ticks M-1, M and M+1. The bit value is their majority, resolved at tick M+1.
- States:
  - IDLE: on `rx_s`==0, go to START. That cycle is tick 0 of the start bit.
  - START: at tick M+1, majority 1 means glitch; return to IDLE with no outputs. Otherwise latch `PAR_EN`/`PAR_TYP` for the frame. At tick PRESCALE-1, go to DATA.
  - DATA: shift in the majority at tick M+1. After bit 7's tick PRESCALE-1, go to PARITY if the latched `PAR_EN`=1, else STOP.
  - PARITY: at tick M+1, compare the received bit with the expected bit. Expected = XOR(data) for even, ~XOR(data) for odd. Record any mismatch.
  - STOP: at tick M+1, resolve the stop bit and go to IDLE on the next cycle.
- Frame completion (cycle after the stop tick M+1):
  - `P_DATA` loads the shift register on every completed frame, including errored frames.
  - `par_err` and `stp_err` pulse as applicable.
  - `data_valid` pulses only if both error flags are 0.
- Break handling: after `stp_err`, IDLE does not arm until `rx_s` has been seen high for one cycle.
- `PAR_EN`/`PAR_TYP` changes mid-frame are ignored until the next start.

## Timing
- Tick 0 = cycle 0. Outputs pulse at cycle (9+P)·PRESCALE + M + 2, where P = latched `PAR_EN`.
  - PRESCALE=8, P=0: cycle 78.
  - PRESCALE=8, P=1: cycle 86.
- `busy` rises the cycle after tick 0. It falls in the same cycle the outputs pulse.
- Back-to-back frames: the next start edge may arrive at any time from stop tick M+2 onward and is captured with no frame loss.
- `rst` mid-frame: next cycle is IDLE, all outputs 0, `P_DATA`=0, counters 0, break-wait flag cleared.
- Majority resolves ties impossible (3 samples). Counters wrap only via explicit state-transition reset.

## Configuration
- `UART_RX_SYNC_EN`:
  - Defined: `RX_IN` passes through a 2-flop synchronizer (reset value 1) to form `rx_s`. Every latency figure above gains +2 cycles, referenced to `RX_IN`.
  - Undefined: `rx_s` = `RX_IN` directly, for synchronous loopback benches.

## Test plan
- Byte 0xA5, `PAR_EN`=0, PRESCALE=8, macro off, drive the falling edge at cycle 0: `data_valid` pulses at cycle 78, `P_DATA`=0xA5, `busy` high for cycles 1..77, no errors.
- Byte 0x3C, even parity with parity bit 0: `data_valid` pulses at cycle 86 with `P_DATA`=0x3C. Repeat with parity bit 1: `par_err` pulses at cycle 86, `data_valid` stays 0, `P_DATA`=0x3C.
- `RX_IN` low for 2 cycles, then high: `busy` high for cycles 1..5, back to IDLE at tick M+1, no pulse on any output.
- Frame 0x55 with stop bit 0 and line held low 40 more cycles: `stp_err` pulses once at cycle 78, no new START until `RX_IN` returns high, then a following 0x81 frame yields `data_valid` with `P_DATA`=0x81.
- Loopback: the transmitter clocked at clk/8 sends 0x00, 0xFF, 0x96 back-to-back, odd parity: three `data_valid` pulses with matching `P_DATA`, no errors. Repeat with `UART_RX_SYNC_EN` defined: same result, each pulse 2 cycles later.
- `rst` asserted one cycle during DATA bit 4: all outputs 0 next cycle, the partial frame is discarded, and a following 0x12 frame is received cleanly.
